// File: rtl/prog_loader.sv
// Serial bootloader: receives a framed 8N1 program image, writes it into
// program memory and releases the CPU once the checksum verifies.
module prog_loader #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_in,
    output logic [11:0] mem_addr,
    output logic [7:0]  mem_data,
    output logic        mem_we,
    output logic        cpu_hold,
    output logic        done,
    output logic        err,
    output logic [11:0] byte_count
);

    localparam int unsigned CNT_W   = $clog2(CLKS_PER_BIT);
    localparam int unsigned HALF_M1 = CLKS_PER_BIT / 2 - 1;
    localparam int unsigned FULL_M1 = CLKS_PER_BIT - 1;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    typedef enum logic [2:0] {
        S_WAIT_SYNC,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_e;

    // ------------------------------------------------------------------
    // UART receiver
    // ------------------------------------------------------------------
    logic             rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_e        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       rx_byte_q, rx_byte_d;
    logic             byte_valid_q, byte_valid_d;
    logic             frame_err_q, frame_err_d;

    // Two-flop synchronizer plus one delay stage for falling-edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx_in;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // Receiver state and bit-timing registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_state_q   <= RX_IDLE;
            clk_cnt_q    <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            rx_byte_q    <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            rx_state_q   <= rx_state_d;
            clk_cnt_q    <= clk_cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            rx_byte_q    <= rx_byte_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    // Receiver next state: half-bit start recheck, then full-bit sample spacing
    always_comb begin
        rx_state_d   = rx_state_q;
        clk_cnt_d    = clk_cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        rx_byte_d    = rx_byte_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        unique case (rx_state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_sync_q) begin
                    rx_state_d = RX_START;
                    clk_cnt_d  = '0;
                end
            end
            RX_START: begin
                if (clk_cnt_q == CNT_W'(HALF_M1)) begin
                    clk_cnt_d = '0;
                    bit_idx_d = '0;
                    // A high line at mid-start is a glitch, not a byte
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (clk_cnt_q == CNT_W'(FULL_M1)) begin
                    clk_cnt_d = '0;
                    shift_d   = {rx_sync_q, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (clk_cnt_q == CNT_W'(FULL_M1)) begin
                    clk_cnt_d  = '0;
                    rx_state_d = RX_IDLE;
                    if (rx_sync_q) begin
                        byte_valid_d = 1'b1;
                        rx_byte_d    = shift_q;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Frame parser and memory writer
    // ------------------------------------------------------------------
    state_e      state_q, state_d;
    logic [11:0] len_q, len_d;
    logic [11:0] byte_count_q, byte_count_d;
    logic [11:0] mem_addr_q, mem_addr_d;
    logic [7:0]  mem_data_q, mem_data_d;
    logic        mem_we_q, mem_we_d;
    logic [7:0]  sum_q, sum_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        cpu_hold_q, cpu_hold_d;
    logic        is_sync;
    logic [11:0] len_full;

    assign is_sync  = byte_valid_q && (rx_byte_q == SYNC_BYTE);
    assign len_full = {len_q[11:8], rx_byte_q};

    // Frame FSM state and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_WAIT_SYNC;
            len_q        <= '0;
            byte_count_q <= '0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            mem_we_q     <= 1'b0;
            sum_q        <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            cpu_hold_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            byte_count_q <= byte_count_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            mem_we_q     <= mem_we_d;
            sum_q        <= sum_d;
            done_q       <= done_d;
            err_q        <= err_d;
            cpu_hold_q   <= cpu_hold_d;
        end
    end

    // Frame FSM next state; writes take two cycles (strobe, then advance)
    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        byte_count_d = byte_count_q;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        mem_we_d     = 1'b0;
        sum_d        = sum_q;
        unique case (state_q)
            S_WAIT_SYNC, S_ERR: begin
                if (is_sync) begin
                    state_d      = S_LEN_HI;
                    byte_count_d = '0;
                    mem_addr_d   = '0;
                    sum_d        = '0;
                end
            end
            S_LEN_HI: begin
                if (byte_valid_q) begin
                    if (rx_byte_q[7:4] != 4'd0) begin
                        state_d = S_ERR;
                    end else begin
                        len_d   = {rx_byte_q[3:0], 8'd0};
                        state_d = S_LEN_LO;
                    end
                end
            end
            S_LEN_LO: begin
                if (byte_valid_q) begin
                    len_d   = len_full;
                    state_d = (len_full == 12'd0) ? S_CSUM : S_DATA;
                end
            end
            S_DATA: begin
                if (mem_we_q) begin
                    byte_count_d = byte_count_q + 12'd1;
                    mem_addr_d   = mem_addr_q + 12'd1;
                    sum_d        = sum_q + mem_data_q;
                    if (byte_count_q + 12'd1 == len_q) begin
                        state_d = S_CSUM;
                    end
                end else if (byte_valid_q) begin
                    mem_we_d   = 1'b1;
                    mem_data_d = rx_byte_q;
                    mem_addr_d = byte_count_q;
                end
            end
            S_CSUM: begin
                if (byte_valid_q) begin
                    state_d = (rx_byte_q == sum_q) ? S_DONE : S_ERR;
                end
            end
            S_DONE: state_d = S_DONE;
            default: state_d = S_WAIT_SYNC;
        endcase
        // A framing error aborts anything short of a completed load
        if (frame_err_q && state_q != S_DONE) begin
            state_d = S_ERR;
        end
        done_d     = (state_d == S_DONE);
        err_d      = (state_d == S_ERR);
        cpu_hold_d = (state_d != S_DONE);
    end

    assign mem_addr   = mem_addr_q;
    assign mem_data   = mem_data_q;
    assign mem_we     = mem_we_q;
    assign cpu_hold   = cpu_hold_q;
    assign done       = done_q;
    assign err        = err_q;
    assign byte_count = byte_count_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: frames are bit-banged onto rx_in and
// memory writes are captured for comparison with hand-computed images.
module tb_prog_loader;

    localparam int unsigned CPB = 16;

    logic        clk;
    logic        reset;
    logic        rx_in;
    logic [11:0] mem_addr;
    logic [7:0]  mem_data;
    logic        mem_we;
    logic        cpu_hold;
    logic        done;
    logic        err;
    logic [11:0] byte_count;

    int n_cmp;
    int n_err;

    logic [11:0] wa_q[$];
    logic [7:0]  wd_q[$];

    prog_loader #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(8'hA5)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_in      (rx_in),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_we     (mem_we),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .err        (err),
        .byte_count (byte_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Capture every write strobe
    always @(negedge clk) begin
        if (reset && mem_we) begin
            wa_q.push_back(mem_addr);
            wd_q.push_back(mem_data);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_wr(input int idx, input logic [11:0] a, input logic [7:0] d);
        if (idx < wa_q.size()) begin
            check($sformatf("wr%0d_addr", idx), 32'(wa_q[idx]), 32'(a));
            check($sformatf("wr%0d_data", idx), 32'(wd_q[idx]), 32'(d));
        end else begin
            check($sformatf("wr%0d_missing", idx), 32'(wa_q.size()), 32'(idx + 1));
        end
    endtask

    task automatic send_bit(input logic v);
        rx_in = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop_bit);
        rx_in = 1'b1;
    endtask

    task automatic idle(input int n);
        rx_in = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rx_in = 1'b1;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        wa_q.delete();
        wd_q.delete();
        reset = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic check_status(input string tag, input logic d, input logic e, input logic h);
        check({tag, "_done"},     32'(done),     32'(d));
        check({tag, "_err"},      32'(err),      32'(e));
        check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'(h));
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rx_in = 1'b1;
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Reset values
        check("rst_mem_addr",   32'(mem_addr),   32'h0);
        check("rst_mem_data",   32'(mem_data),   32'h0);
        check("rst_mem_we",     32'(mem_we),     32'h0);
        check("rst_byte_count", 32'(byte_count), 32'h0);
        check_status("rst", 1'b0, 1'b0, 1'b1);
        reset = 1'b1;
        idle(5);

        // Nominal load: 12+34+56 = 9C
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h03);
        send_byte(8'h12); send_byte(8'h34); send_byte(8'h56);
        send_byte(8'h9C);
        idle(8);
        check("nom_nwr", 32'(wa_q.size()), 32'd3);
        check_wr(0, 12'd0, 8'h12);
        check_wr(1, 12'd1, 8'h34);
        check_wr(2, 12'd2, 8'h56);
        check_status("nom", 1'b1, 1'b0, 1'b0);
        check("nom_byte_count", 32'(byte_count), 32'd3);
        // DONE ignores further traffic
        send_byte(8'hA5);
        idle(8);
        check_status("nom_sticky", 1'b1, 1'b0, 1'b0);

        // Bad checksum (sum 03, sent 00), then recovery frame
        do_reset();
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h00);
        idle(8);
        check("bad_nwr", 32'(wa_q.size()), 32'd2);
        check_wr(0, 12'd0, 8'h01);
        check_wr(1, 12'd1, 8'h02);
        check_status("bad", 1'b0, 1'b1, 1'b1);
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
        send_byte(8'hFF); send_byte(8'hFF);
        idle(8);
        check("rec_nwr", 32'(wa_q.size()), 32'd3);
        check_wr(2, 12'd0, 8'hFF);
        check_status("rec", 1'b1, 1'b0, 1'b0);
        check("rec_byte_count", 32'(byte_count), 32'd1);

        // Noise bytes and a short glitch before a zero-length frame
        do_reset();
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
        idle(4);
        check_status("noise", 1'b0, 1'b0, 1'b1);
        rx_in = 1'b0;
        repeat (4) @(negedge clk);
        idle(3 * CPB);
        check_status("glitch", 1'b0, 1'b0, 1'b1);
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        idle(8);
        check("zero_nwr", 32'(wa_q.size()), 32'd0);
        check_status("zero", 1'b1, 1'b0, 1'b0);
        check("zero_byte_count", 32'(byte_count), 32'd0);

        // Framing error on LEN_LO
        do_reset();
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h03, 1'b0);
        idle(2 * CPB);
        check("ferr_nwr", 32'(wa_q.size()), 32'd0);
        check_status("ferr", 1'b0, 1'b1, 1'b1);

        // Length high nibble out of range
        do_reset();
        send_byte(8'hA5); send_byte(8'h1F);
        idle(8);
        check_status("len", 1'b0, 1'b1, 1'b1);
        check("len_nwr", 32'(wa_q.size()), 32'd0);

        // Asynchronous reset midway through the second data byte
        do_reset();
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h03); send_byte(8'h11);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        check("mid_byte_count_pre", 32'(byte_count), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("arst_byte_count", 32'(byte_count), 32'd0);
        check("arst_mem_addr",   32'(mem_addr),   32'd0);
        check("arst_mem_data",   32'(mem_data),   32'd0);
        check("arst_mem_we",     32'(mem_we),     32'd0);
        check_status("arst", 1'b0, 1'b0, 1'b1);
        rx_in = 1'b1;
        repeat (3) @(negedge clk);
        wa_q.delete();
        wd_q.delete();
        reset = 1'b1;
        idle(2 * CPB);
        // AB+CD = 178 -> 78
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
        send_byte(8'hAB); send_byte(8'hCD); send_byte(8'h78);
        idle(8);
        check("post_nwr", 32'(wa_q.size()), 32'd2);
        check_wr(0, 12'd0, 8'hAB);
        check_wr(1, 12'd1, 8'hCD);
        check_status("post", 1'b1, 1'b0, 1'b0);
        check("post_byte_count", 32'(byte_count), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Serial bootloader: the write side of the program memory the Nibbler core fetches from.
- Receives a framed program image on a UART line (8N1) and writes each byte into program memory through a simple write port.
- Holds the CPU in reset until a complete image with a valid checksum has been loaded.
- Sits beside the core at top level: drives the program-memory write port and the core's hold/reset input.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per UART bit; must be ≥ 4 and even.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- rx_in  in  1  UART receive line, idle high, asynchronous to clk.
- mem_addr  out  12  program-memory write address.
- mem_data  out  8  program-memory write data.
- mem_we  out  1  one-cycle write strobe.
- cpu_hold  out  1  high = keep CPU in reset.
- done  out  1  image loaded and verified.
- err  out  1  framing, length or checksum error.
- byte_count  out  12  number of data bytes written in the current frame.

Behaviour:
- Reset (reset=0, takes effect immediately):
  - mem_addr=0, mem_data=0, mem_we=0, byte_count=0, done=0, err=0.
  - cpu_hold=1.
  - FSM goes to WAIT_SYNC; UART receiver goes to RX_IDLE.
  - A reset in the middle of a frame discards the partial frame. Memory already written is not cleared.
- UART receiver:
  - rx_in passes through a 2-flop synchronizer.
  - A falling edge while in RX_IDLE starts bit timing.
  - Start bit is re-checked at CLKS_PER_BIT/2. If it reads high, treat it as a glitch and return to RX_IDLE with no error.
  - Eight data bits are sampled LSB first, each one CLKS_PER_BIT after the previous sample.
  - Stop bit is sampled CLKS_PER_BIT later:
    - stop=1: pulse byte_valid internally for 1 cycle with rx_byte.
    - stop=0: framing error; the FSM goes to ERR.
  - Receiver returns to RX_IDLE right after the stop sample. Back-to-back bytes are supported.
- Frame format: SYNC_BYTE, LEN_HI, LEN_LO, LEN data bytes, CSUM.
  - LEN = {LEN_HI[3:0], LEN_LO}.
  - CSUM = 8-bit sum, modulo 256, of the data bytes.
- FSM (advances only on byte_valid unless stated otherwise):
  - WAIT_SYNC: bytes other than SYNC_BYTE are ignored. SYNC_BYTE → LEN_HI; clear byte_count, mem_addr, and the running sum.
  - LEN_HI: LEN_HI[7:4] ≠ 0 → ERR; otherwise store and go to LEN_LO.
  - LEN_LO: store. LEN = 0 → CSUM; otherwise → DATA.
  - DATA: each byte is written to memory as described below. When byte_count reaches LEN → CSUM.
  - CSUM: received byte equals the running sum → DONE; otherwise → ERR.
  - DONE: done=1, cpu_hold=0. Further bytes are ignored. Only reset leaves DONE.
  - ERR: err=1, cpu_hold=1. A SYNC_BYTE clears err and goes to LEN_HI, so a new frame restarts; other bytes are ignored.
- Memory write timing:
  - In the cycle after a data byte's byte_valid: mem_we=1, mem_data=byte, mem_addr=byte_count.
  - In the following cycle: mem_we=0, byte_count and mem_addr increment, and the byte is added to the sum.
  - mem_addr and mem_data hold their values when mem_we=0.
- Width rules:
  - LEN maximum is 4095; byte_count never wraps.
  - The sum wraps modulo 256.
- Simultaneous events: reset dominates all. A framing error in any state except DONE forces ERR.

Test Plan:
- Nominal load: send A5 00 03 12 34 56 9C (CLKS_PER_BIT=16) → mem_we pulses 3 times with addr 0,1,2 and data 12,34,56; then done=1, cpu_hold=0, err=0, byte_count=3.
- Bad checksum: A5 00 02 01 02 00 → two writes occur, then err=1, cpu_hold=1, done=0. Then send A5 00 01 FF FF → err=0, done=1.
- Noise before sync: 00 FF 5A, then a 4-cycle low glitch on rx_in, then A5 00 00 00 → glitch ignored, no writes, done=1.
- Framing error: drive stop bit low on the LEN_LO byte → err=1, no mem_we, cpu_hold=1.
- Length check: A5 1F … → err=1 immediately after LEN_HI.
- Async reset: assert reset low mid-way through the 2nd data byte → all outputs return to reset values at once (cpu_hold=1). After release, a full frame loads correctly starting at addr 0.
